// File: rtl/sram_port_ctl.sv
// ---------------------------------------------------------------------------
// sram_port_ctl
//
// Single-port access controller for one toy-SRAM array. It sits between the
// Caravel logic-analyzer (LA) bus and the array's read/write port. Word
// accesses from the management core arrive over LA bits using a 4-phase
// req/ack handshake. A built-in march self-test (W0, R0, W1, R1) can be
// started by a rising edge on bist_go. Every array cycle is sequenced here
// and results are reported back over LA outputs.
//
// Ports
//   clk         : sole clock, rising edge
//   reset       : synchronous, active-high
//   la_data_in  : [0] req, [1] wr, [2] bist_go, [8+:ADDR_W] addr,
//                 [32+:DATA_W] wdata
//   la_oen      : active-low drive enable per LA bit (1 forces that input to 0)
//   la_data_out : [0] ack, [1] busy, [2] bist_done, [3] bist_fail,
//                 [8+:ADDR_W] bist_fail_addr, [32+:DATA_W] rdata, rest 0
//   sram_re     : array read enable (data returns the following cycle)
//   sram_we     : array write enable
//   sram_addr   : array address
//   sram_wdata  : array write data
//   sram_rdata  : array read data
// ---------------------------------------------------------------------------
module sram_port_ctl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [127:0]      la_data_in,
    input  logic [127:0]      la_oen,
    output logic [127:0]      la_data_out,
    output logic              sram_re,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_WR    = 4'd1;
    localparam logic [3:0] ST_RD    = 4'd2;
    localparam logic [3:0] ST_RDCAP = 4'd3;
    localparam logic [3:0] ST_ACK   = 4'd4;
    localparam logic [3:0] ST_BW0   = 4'd5;
    localparam logic [3:0] ST_BR0   = 4'd6;
    localparam logic [3:0] ST_BW1   = 4'd7;
    localparam logic [3:0] ST_BR1   = 4'd8;

    localparam logic [2*DATA_W-1:0] PAT_FULL = {DATA_W{2'b01}};
    localparam logic [DATA_W-1:0]   PAT      = PAT_FULL[DATA_W-1:0];

    // LA bits this block actually decodes; everything else is folded away.
    localparam logic [127:0] USED_MASK = {{(96-DATA_W){1'b0}}, {DATA_W{1'b1}},
                                          {(24-ADDR_W){1'b0}}, {ADDR_W{1'b1}},
                                          5'b0, 3'b111};

    logic [127:0]      laIn;
    logic              reqIn;
    logic              wrIn;
    logic              goIn;
    logic [ADDR_W-1:0] addrIn;
    logic [DATA_W-1:0] wdataIn;
    logic              goEdge;
    logic              unused_laBits;

    // Undriven LA bits (la_oen high) read as 0.
    assign laIn    = la_data_in & ~la_oen;
    assign reqIn   = laIn[0];
    assign wrIn    = laIn[1];
    assign goIn    = laIn[2];
    assign addrIn  = laIn[8 +: ADDR_W];
    assign wdataIn = laIn[32 +: DATA_W];
    assign unused_laBits = ^(laIn & ~USED_MASK);

    logic [3:0]        state_q,     state_d;
    logic [ADDR_W-1:0] cnt_q,       cnt_d;
    logic              drain_q,     drain_d;
    logic              goPrev_q;
    logic              goPend_q,    goPend_d;
    logic              ack_q,       ack_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              fail_q,      fail_d;
    logic [ADDR_W-1:0] failAddr_q,  failAddr_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              re_q,        re_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              pipeV1_q,    pipeV1_d;
    logic [DATA_W-1:0] pipeExp1_q,  pipeExp1_d;
    logic              pipeV2_q;
    logic [ADDR_W-1:0] pipeAddr2_q;
    logic [DATA_W-1:0] pipeExp2_q;

    assign goEdge = goIn & ~goPrev_q;

    // Next-state and next-output logic. Outputs are computed from the state
    // being entered so that every array strobe leaves a flop. cnt_q holds the
    // next address of the current march phase; its wrap to 0 marks the end.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        goPend_d   = goPend_q;
        done_d     = done_q;
        fail_d     = fail_q;
        failAddr_d = failAddr_q;
        rdata_d    = rdata_q;
        re_d       = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pipeV1_d   = 1'b0;
        pipeExp1_d = pipeExp1_q;

        // BIST read data returns two edges after issue; only the first
        // mismatch is recorded.
        if (pipeV2_q && (sram_rdata != pipeExp2_q) && !fail_q) begin
            fail_d     = 1'b1;
            failAddr_d = pipeAddr2_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (reqIn) begin
                    state_d = wrIn ? ST_WR : ST_RD;
                    we_d    = wrIn;
                    re_d    = ~wrIn;
                    addr_d  = addrIn;
                    if (wrIn) begin
                        wdata_d = wdataIn;
                    end
                    if (goEdge) begin
                        goPend_d = 1'b1;
                    end
                end else if (goEdge || goPend_q) begin
                    state_d    = ST_BW0;
                    we_d       = 1'b1;
                    addr_d     = '0;
                    wdata_d    = PAT;
                    cnt_d      = ADDR_W'(1);
                    drain_d    = 1'b0;
                    goPend_d   = 1'b0;
                    done_d     = 1'b0;
                    fail_d     = 1'b0;
                    failAddr_d = '0;
                end
            end
            ST_WR:    state_d = ST_ACK;
            ST_RD:    state_d = ST_RDCAP;
            ST_RDCAP: begin
                rdata_d = sram_rdata;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!reqIn) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BW0, ST_BW1: begin
                if (cnt_q == '0) begin
                    state_d    = (state_q == ST_BW0) ? ST_BR0 : ST_BR1;
                    re_d       = 1'b1;
                    addr_d     = '0;
                    pipeV1_d   = 1'b1;
                    pipeExp1_d = (state_q == ST_BW0) ? PAT : ~PAT;
                    cnt_d      = ADDR_W'(1);
                end else begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = (state_q == ST_BW0) ? PAT : ~PAT;
                    cnt_d   = cnt_q + ADDR_W'(1);
                end
            end
            ST_BR0, ST_BR1: begin
                if (drain_q) begin
                    drain_d = 1'b0;
                    if (state_q == ST_BR0) begin
                        state_d = ST_BW1;
                        we_d    = 1'b1;
                        addr_d  = '0;
                        wdata_d = ~PAT;
                        cnt_d   = ADDR_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (cnt_q == '0) begin
                    drain_d = 1'b1;
                end else begin
                    re_d       = 1'b1;
                    addr_d     = cnt_q;
                    pipeV1_d   = 1'b1;
                    pipeExp1_d = (state_q == ST_BR0) ? PAT : ~PAT;
                    cnt_d      = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ack_d  = (state_d == ST_ACK);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers. On reset the bist_go history takes the
    // current input so a level held through reset cannot restart BIST.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            goPrev_q    <= goIn;
            goPend_q    <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            failAddr_q  <= '0;
            rdata_q     <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pipeV1_q    <= 1'b0;
            pipeExp1_q  <= '0;
            pipeV2_q    <= 1'b0;
            pipeAddr2_q <= '0;
            pipeExp2_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            goPrev_q    <= goIn;
            goPend_q    <= goPend_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            failAddr_q  <= failAddr_d;
            rdata_q     <= rdata_d;
            re_q        <= re_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pipeV1_q    <= pipeV1_d;
            pipeExp1_q  <= pipeExp1_d;
            pipeV2_q    <= pipeV1_q;
            pipeAddr2_q <= addr_q;
            pipeExp2_q  <= pipeExp1_q;
        end
    end

    assign sram_re    = re_q;
    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    always_comb begin
        la_data_out                = '0;
        la_data_out[0]             = ack_q;
        la_data_out[1]             = busy_q;
        la_data_out[2]             = done_q;
        la_data_out[3]             = fail_q;
        la_data_out[8 +: ADDR_W]   = failAddr_q;
        la_data_out[32 +: DATA_W]  = rdata_q;
    end

endmodule
